// File: rtl/mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// mem_responder_pkg
//
// Purpose:
//   Shared definitions for the handshaked memory responder: the FSM state
//   encoding, the wait-state counter width and the lane geometry of a
//   32-bit word built from four little-endian bytes.
//
// Contents:
//   state_t  - IDLE / WAIT / RESP state encoding
//   LAT_W    - wait-state counter width
//   LAT_MAX  - largest wait-state count the counter can hold
//   LANES    - byte lanes per word
//   BYTE_W   - bits per byte lane
//   WORD_W   - bits per word
// ---------------------------------------------------------------------------
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int LAT_W   = 4;
    localparam int LAT_MAX = (1 << LAT_W) - 1;
    localparam int LANES   = 4;
    localparam int BYTE_W  = 8;
    localparam int WORD_W  = LANES * BYTE_W;

endpackage

// File: rtl/mem_responder_array.sv
// ---------------------------------------------------------------------------
// mem_responder_array
//
// Purpose:
//   Byte-addressed storage for the responder. A word access touches the
//   bytes at addr, addr+1, addr+2 and addr+3; each lane address wraps
//   modulo the array depth, so a word may straddle the top of the array
//   and continue at byte 0. No alignment is required.
//
// Parameters:
//   ADDR_W   - byte address width; depth = 2**ADDR_W bytes
//
// Ports:
//   clk      in   clock, rising edge (writes only)
//   we       in   word write strobe
//   lane_en  in   per-lane write enable, lane i = bits [8i+7:8i]
//   addr     in   byte address of lane 0
//   wdata    in   write word
//   rdata    out  combinational read word, registered by the parent
// ---------------------------------------------------------------------------
module mem_responder_array
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [LANES-1:0]  lane_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [BYTE_W-1:0] storage [2**ADDR_W];
    logic [ADDR_W-1:0] lane_addr [LANES];

    // Lane addresses are plain ADDR_W-bit sums, so the carry out of the top
    // bit is dropped and the wrap-around comes for free.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_addr[i] = addr + ADDR_W'(i);
        end
    end

    // Storage has no reset; contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (we) begin
            if (lane_en[0]) storage[lane_addr[0]] <= wdata[7:0];
            if (lane_en[1]) storage[lane_addr[1]] <= wdata[15:8];
            if (lane_en[2]) storage[lane_addr[2]] <= wdata[23:16];
            if (lane_en[3]) storage[lane_addr[3]] <= wdata[31:24];
        end
    end

    // Little-endian assembly: the lowest address lands in the low byte.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < LANES; i++) begin
            rdata[i*BYTE_W +: BYTE_W] = storage[lane_addr[i]];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Purpose:
//   Memory-side responder for the multicycle CPU's load/store path. One
//   request is accepted in IDLE, LATENCY wait states are inserted, and the
//   access is committed on the edge that enters RESP, where ready pulses
//   for one cycle. Requests arriving while busy are ignored.
//   Addresses with any bit set above ADDR_W are out of range: writes are
//   dropped, reads return zero, and err pulses with ready.
//
// Parameters:
//   ADDR_W   - byte address bits decoded (depth 2**ADDR_W bytes)
//   LATENCY  - wait states before the response, 0..15
//
// Build option:
//   MEM_RESPONDER_BYTE_EN - adds the byte_en port; writes then update only
//                           the enabled lanes. Without it all four lanes
//                           are written.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   req      in   request level, sampled only in IDLE
//   address  in   byte address
//   wr       in   1 = write, 0 = read
//   datain   in   write data
//   byte_en  in   per-lane write enable (MEM_RESPONDER_BYTE_EN only)
//   busy     out  high in WAIT and RESP
//   ready    out  one-cycle completion pulse
//   dataout  out  read data, valid with ready and held afterwards
//   err      out  out-of-range flag, pulses with ready
// ---------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [31:0]       address,
    input  logic              wr,
    input  logic [31:0]       datain,
`ifdef MEM_RESPONDER_BYTE_EN
    input  logic [LANES-1:0]  byte_en,
`endif
    output logic              busy,
    output logic              ready,
    output logic [31:0]       dataout,
    output logic              err
);

    // Reject wait-state counts the counter cannot represent.
    generate
        if (LATENCY < 0 || LATENCY > LAT_MAX) begin : g_latency_check
            $error("mem_responder: LATENCY must be within 0..15");
        end
    endgenerate

    localparam logic [LAT_W-1:0] LAT_INIT =
        (LATENCY == 0) ? '0 : LAT_W'(LATENCY - 1);

    state_t            state;
    state_t            next_state;
    logic [LAT_W-1:0]  counter;
    logic [LAT_W-1:0]  counter_next;

    logic [31:0]       req_addr;
    logic              req_wr;
    logic [31:0]       req_data;
    logic [31:0]       dataout_q;
    logic              oor_q;

    logic              accept;
    logic              commit;
    logic [31:0]       cur_addr;
    logic              cur_wr;
    logic [31:0]       cur_data;
    logic [LANES-1:0]  cur_lanes;
    logic              cur_oor;
    logic              array_we;
    logic [WORD_W-1:0] array_rdata;

`ifdef MEM_RESPONDER_BYTE_EN
    logic [LANES-1:0]  req_be;
`endif

    // The commit edge usually comes from WAIT and uses the latched request,
    // but with LATENCY=0 the accept edge is also the commit edge, so the
    // live inputs must be used while still in IDLE.
    always_comb begin
        cur_addr = (state == ST_IDLE) ? address : req_addr;
        cur_wr   = (state == ST_IDLE) ? wr      : req_wr;
        cur_data = (state == ST_IDLE) ? datain  : req_data;
`ifdef MEM_RESPONDER_BYTE_EN
        cur_lanes = (state == ST_IDLE) ? byte_en : req_be;
`else
        cur_lanes = '1;
`endif
        cur_oor = |cur_addr[31:ADDR_W];
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        next_state   = state;
        counter_next = counter;
        accept       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        next_state = ST_RESP;
                    end else begin
                        next_state   = ST_WAIT;
                        counter_next = LAT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (counter == '0) begin
                    next_state = ST_RESP;
                end else begin
                    counter_next = counter - 1'b1;
                end
            end
            ST_RESP: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        commit  = (next_state == ST_RESP) && (state != ST_RESP);
        busy    = (state != ST_IDLE);
        ready   = (state == ST_RESP);
        err     = (state == ST_RESP) && oor_q;
        dataout = dataout_q;
    end

    // Reset wins over a coinciding commit edge, so the storage write is
    // gated here rather than only through the state register.
    assign array_we = commit && cur_wr && !cur_oor && !rst;

    // State, counter, latched request and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            counter   <= '0;
            req_addr  <= '0;
            req_wr    <= 1'b0;
            req_data  <= '0;
            dataout_q <= '0;
            oor_q     <= 1'b0;
`ifdef MEM_RESPONDER_BYTE_EN
            req_be    <= '0;
`endif
        end else begin
            state   <= next_state;
            counter <= counter_next;
            if (accept) begin
                req_addr <= address;
                req_wr   <= wr;
                req_data <= datain;
`ifdef MEM_RESPONDER_BYTE_EN
                req_be   <= byte_en;
`endif
            end
            if (commit) begin
                oor_q <= cur_oor;
                if (!cur_wr) begin
                    dataout_q <= cur_oor ? '0 : array_rdata;
                end
            end
        end
    end

    mem_responder_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .we      (array_we),
        .lane_en (cur_lanes),
        .addr    (cur_addr[ADDR_W-1:0]),
        .wdata   (cur_data),
        .rdata   (array_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//
// Bench for mem_responder. A LATENCY=1 instance carries the directed table,
// the randomized traffic and the reset-abort sequence; LATENCY=0 and
// LATENCY=15 instances are used for the back-to-back throughput sweep.
// Expected read data comes from a byte-array model indexed with modular
// arithmetic. Define MEM_RESPONDER_BYTE_EN to also exercise lane enables.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] mask;
        logic [31:0] exp;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr;
    logic [31:0] address;
    logic [31:0] datain;
`ifdef MEM_RESPONDER_BYTE_EN
    logic [3:0]  byte_en;
`endif
    logic        busy, ready, err;
    logic [31:0] dataout;

    logic        req0, req15;
    logic        sweep_wr;
    logic [31:0] sweep_addr;
    logic [31:0] sweep_data;
`ifdef MEM_RESPONDER_BYTE_EN
    logic [3:0]  sweep_be;
`endif
    logic        busy0, ready0, err0;
    logic [31:0] dataout0;
    logic        busy15, ready15, err15;
    logic [31:0] dataout15;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  model [256];
    vec_t        vecs [9];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .LATENCY(1)) dut (
        .clk(clk), .rst(rst), .req(req), .address(address), .wr(wr),
        .datain(datain),
`ifdef MEM_RESPONDER_BYTE_EN
        .byte_en(byte_en),
`endif
        .busy(busy), .ready(ready), .dataout(dataout), .err(err)
    );

    mem_responder #(.ADDR_W(8), .LATENCY(0)) dut_l0 (
        .clk(clk), .rst(rst), .req(req0), .address(sweep_addr), .wr(sweep_wr),
        .datain(sweep_data),
`ifdef MEM_RESPONDER_BYTE_EN
        .byte_en(sweep_be),
`endif
        .busy(busy0), .ready(ready0), .dataout(dataout0), .err(err0)
    );

    mem_responder #(.ADDR_W(8), .LATENCY(15)) dut_l15 (
        .clk(clk), .rst(rst), .req(req15), .address(sweep_addr), .wr(sweep_wr),
        .datain(sweep_data),
`ifdef MEM_RESPONDER_BYTE_EN
        .byte_en(sweep_be),
`endif
        .busy(busy15), .ready(ready15), .dataout(dataout15), .err(err15)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, actual, expected);
        end
    endtask

    // One complete transaction on the LATENCY=1 instance. lat counts clock
    // edges after the accept edge until ready is seen (bounded at 40).
    task automatic applyStimulus(input logic w, input logic [31:0] a,
                                 input logic [31:0] d, output int lat,
                                 output logic [31:0] dout, output logic e,
                                 output logic busy_after_accept,
                                 output logic ready_after, output logic busy_after);
        req = 1'b1;
        wr = w;
        address = a;
        datain = d;
        @(posedge clk);
        #1;
        req = 1'b0;
        busy_after_accept = busy;
        lat = 0;
        while (!ready && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        dout = dataout;
        e = err;
        @(posedge clk);
        #1;
        ready_after = ready;
        busy_after = busy;
    endtask

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        logic [31:0] word = '0;
        for (int i = 0; i < 4; i++) begin
            word[i*8 +: 8] = model[(int'(a[7:0]) + i) % 256];
        end
        return word;
    endfunction

    // Transaction checked against the model; the model is updated afterwards.
    task automatic runOp(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input string tag);
        int          lat;
        logic [31:0] dout;
        logic        e, ba, ra, bb;
        logic        oor;
        logic [31:0] exp_data;
        oor = (a >= 32'd256);
        exp_data = oor ? 32'h0 : modelRead(a);
`ifdef MEM_RESPONDER_BYTE_EN
        byte_en = be;
`endif
        applyStimulus(w, a, d, lat, dout, e, ba, ra, bb);
        checkOutput({tag, " latency"}, 32'(lat), 32'd1);
        checkOutput({tag, " err"}, {31'd0, e}, {31'd0, oor});
        checkOutput({tag, " ready pulse width"}, {31'd0, ra}, 32'd0);
        if (!w) checkOutput({tag, " dataout"}, dout, exp_data);
        if (w && !oor) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) model[(int'(a[7:0]) + i) % 256] = d[i*8 +: 8];
            end
        end
    endtask

    // Holds req high on the LATENCY=0 or LATENCY=15 instance and measures
    // the spacing of ready pulses and the busy cycles in each period.
    task automatic sweep(input bit use15, input int period_exp);
        int   cyc;
        int   period;
        int   busy_cnt;
        logic rdy;
        logic bsy;
        if (use15) req15 = 1'b1; else req0 = 1'b1;
        cyc = 0;
        rdy = 1'b0;
        while (!rdy && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            rdy = use15 ? ready15 : ready0;
        end
        for (int p = 0; p < 3; p++) begin
            period = 0;
            busy_cnt = 0;
            do begin
                @(posedge clk);
                #1;
                period++;
                rdy = use15 ? ready15 : ready0;
                bsy = use15 ? busy15 : busy0;
                if (bsy) busy_cnt++;
                if (rdy && !bsy) checkOutput("sweep busy with ready", 32'd0, 32'd1);
            end while (!rdy && period < 60);
            checkOutput($sformatf("sweep L%0d period %0d", period_exp - 2, p),
                        32'(period), 32'(period_exp));
            checkOutput($sformatf("sweep L%0d busy cycles %0d", period_exp - 2, p),
                        32'(busy_cnt), 32'(period_exp - 1));
        end
        req0 = 1'b0;
        req15 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
    endtask

    initial begin
        int          lat;
        logic [31:0] dout;
        logic        e, ba, ra, bb;
        logic [31:0] prior;
        logic [31:0] a;
        logic [3:0]  be;

        vecs[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        32'h0,        1'b0};
        vecs[1] = '{1'b0, 32'h10,  32'h0,        32'hFFFFFFFF, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b0, 32'h12,  32'h0,        32'h0000FFFF, 32'h0000DEAD, 1'b0};
        vecs[3] = '{1'b1, 32'hFE,  32'h11223344, 32'h0,        32'h0,        1'b0};
        vecs[4] = '{1'b0, 32'hFE,  32'h0,        32'hFFFFFFFF, 32'h11223344, 1'b0};
        vecs[5] = '{1'b0, 32'h0,   32'h0,        32'h0000FFFF, 32'h00001122, 1'b0};
        vecs[6] = '{1'b0, 32'h100, 32'h0,        32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[7] = '{1'b1, 32'h100, 32'hAAAAAAAA, 32'h0,        32'h0,        1'b1};
        vecs[8] = '{1'b0, 32'h0,   32'h0,        32'h0000FFFF, 32'h00001122, 1'b0};

        rst = 1'b1;
        req = 1'b0; wr = 1'b0; address = '0; datain = '0;
        req0 = 1'b0; req15 = 1'b0;
        sweep_wr = 1'b0; sweep_addr = '0; sweep_data = '0;
`ifdef MEM_RESPONDER_BYTE_EN
        byte_en = 4'hF;
        sweep_be = 4'hF;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset ready", {31'd0, ready}, 32'd0);
        checkOutput("reset err", {31'd0, err}, 32'd0);
        checkOutput("reset dataout", dataout, 32'd0);
        checkOutput("reset L0 outputs", {busy0, ready0, err0, dataout0[28:0]}, 32'd0);
        checkOutput("reset L15 outputs", {busy15, ready15, err15, dataout15[28:0]}, 32'd0);

        // Directed table on the LATENCY=1 instance.
        for (int i = 0; i < 9; i++) begin
`ifdef MEM_RESPONDER_BYTE_EN
            byte_en = 4'hF;
`endif
            applyStimulus(vecs[i].w, vecs[i].a, vecs[i].d, lat, dout, e, ba, ra, bb);
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd1);
            checkOutput($sformatf("vec%0d busy in wait", i), {31'd0, ba}, 32'd1);
            checkOutput($sformatf("vec%0d err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
            checkOutput($sformatf("vec%0d ready one cycle", i), {31'd0, ra}, 32'd0);
            checkOutput($sformatf("vec%0d idle after", i), {31'd0, bb}, 32'd0);
            if (!vecs[i].w) begin
                checkOutput($sformatf("vec%0d dataout", i), dout & vecs[i].mask, vecs[i].exp);
            end
        end

        // Fill the whole array so the model knows every byte.
        for (int k = 0; k < 64; k++) begin
            runOp(1'b1, 32'(k * 4), $urandom, 4'hF, "init");
        end

        // Randomized traffic, including wrapped and out-of-range addresses.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom | 32'h100;
            else a = 32'($urandom_range(0, 255));
`ifdef MEM_RESPONDER_BYTE_EN
            be = 4'($urandom_range(0, 15));
`else
            be = 4'hF;
`endif
            runOp(1'($urandom_range(0, 1)), a, $urandom, be, $sformatf("rand%0d", n));
        end

        // Reset on the commit edge of a write aborts it.
        prior = modelRead(32'h20);
`ifdef MEM_RESPONDER_BYTE_EN
        byte_en = 4'hF;
`endif
        req = 1'b1; wr = 1'b1; address = 32'h20; datain = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort ready", {31'd0, ready}, 32'd0);
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort dataout cleared", dataout, 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 32'h20, 32'h0, lat, dout, e, ba, ra, bb);
        checkOutput("abort readback", dout, prior);

        // Back-to-back throughput at the latency extremes.
        sweep(1'b0, 2);
        sweep(1'b1, 17);

`ifdef MEM_RESPONDER_BYTE_EN
        runOp(1'b1, 32'h30, 32'hFFFFFFFF, 4'hF, "be preset");
        runOp(1'b1, 32'h30, 32'h00000000, 4'b0101, "be partial");
        byte_en = 4'hF;
        applyStimulus(1'b0, 32'h30, 32'h0, lat, dout, e, ba, ra, bb);
        checkOutput("be readback", dout, 32'hFF00FF00);
        runOp(1'b1, 32'h30, 32'h12345678, 4'b0000, "be none");
        byte_en = 4'b0000;
        applyStimulus(1'b0, 32'h30, 32'h0, lat, dout, e, ba, ra, bb);
        checkOutput("be none readback", dout, 32'hFF00FF00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
